// File: rtl/car_motion_ctrl_pkg.sv
// Shared types and constants for the car motion controller.
package car_motion_ctrl_pkg;
   localparam int COORD_W    = 11;
   localparam int X_WRAP_DEF = 640;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HALT
   } state_t;
endpackage

// File: rtl/car_motion_ctrl_pos_step.sv
// Combinational per-frame position step with horizontal wrap.
module car_pos_step
   import car_motion_ctrl_pkg::*;
#(
   parameter int X_WRAP = X_WRAP_DEF
) (
   input  logic [COORD_W-1:0] x0,
   input  logic [1:0]         frac,
   input  logic [5:0]         speed,
   input  logic               dir,
   output logic [COORD_W-1:0] nx,
   output logic [1:0]         nfrac,
   output logic               wrap
);
   localparam logic [11:0] WV = 12'(X_WRAP);

   logic [7:0]  sum;
   logic [11:0] xe;
   logic [11:0] se;
   logic [11:0] t;

   assign sum   = {6'd0, frac} + {2'd0, speed};
   assign nfrac = sum[1:0];
   assign xe    = {1'b0, x0};
   assign se    = {6'd0, sum[7:2]};

   always_comb begin
      t    = xe;
      wrap = 1'b0;
      if (!dir) begin
         t = xe + se;
         if (t >= WV) begin
            t    = t - WV;
            wrap = 1'b1;
         end
      end else if (xe >= se) begin
         t = xe - se;
      end else begin
         t    = xe + WV - se;
         wrap = 1'b1;
      end
   end

   assign nx = t[COORD_W-1:0];
endmodule

// File: rtl/car_motion_ctrl.sv
// Per-car horizontal motion FSM driving a sprite origin.
module car_motion_ctrl
   import car_motion_ctrl_pkg::*;
#(
   parameter int X_WRAP  = X_WRAP_DEF,
   parameter int Y_LANE  = 224,
   parameter int X_START = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_tick,
   input  logic               start,
   input  logic               stop,
   input  logic               pause,
   input  logic               dir,
   input  logic [5:0]         speed,
   output logic [COORD_W-1:0] x0,
   output logic [COORD_W-1:0] y0,
   output logic               moving,
   output logic               wrap
);
   localparam logic [COORD_W-1:0] XS = COORD_W'(X_START);

   state_t             state;
   state_t             state_n;
   logic [1:0]         frac;
   logic [COORD_W-1:0] nx;
   logic [1:0]         nfrac;
   logic               step_wrap;
   logic               upd;

   car_pos_step #(
      .X_WRAP(X_WRAP)
   ) u_step (
      .x0   (x0),
      .frac (frac),
      .speed(speed),
      .dir  (dir),
      .nx   (nx),
      .nfrac(nfrac),
      .wrap (step_wrap)
   );

   assign y0 = COORD_W'(Y_LANE);

   always_comb begin
      state_n = state;
      upd     = 1'b0;
      unique case (state)
         IDLE: if (start && !stop) state_n = RUN;
         RUN: begin
            upd = frame_tick && !pause && !stop;
            if (stop)       state_n = IDLE;
            else if (pause) state_n = HALT;
         end
         HALT: begin
            if (stop)        state_n = IDLE;
            else if (!pause) state_n = RUN;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         x0     <= XS;
         frac   <= 2'd0;
         moving <= 1'b0;
         wrap   <= 1'b0;
      end else begin
         state  <= state_n;
         moving <= (state_n == RUN);
         wrap   <= upd && step_wrap;
         // Leaving for IDLE discards any update in the same cycle.
         if (state_n == IDLE) begin
            x0   <= XS;
            frac <= 2'd0;
         end else if (upd) begin
            x0   <= nx;
            frac <= nfrac;
         end
      end
   end
endmodule

// File: tb/tb_car_motion_ctrl.sv
// Directed self-checking bench for car_motion_ctrl.
module tb_car_motion_ctrl;
   logic        clk = 1'b0;
   logic        reset, frame_tick, start, stop, pause, dir;
   logic [5:0]  speed;
   logic [10:0] x0, y0;
   logic        moving, wrap;
   int          n_cmp = 0;
   int          n_bad = 0;

   car_motion_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .frame_tick(frame_tick),
      .start     (start),
      .stop      (stop),
      .pause     (pause),
      .dir       (dir),
      .speed     (speed),
      .x0        (x0),
      .y0        (y0),
      .moving    (moving),
      .wrap      (wrap)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input string tag, input int ex, input int ew);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      chk({tag, "_x0"}, int'(x0), ex);
      chk({tag, "_wrap"}, int'(wrap), ew);
      step();
      chk({tag, "_wrap_end"}, int'(wrap), 0);
      chk({tag, "_hold"}, int'(x0), ex);
   endtask

   initial begin
      reset = 1'b1; frame_tick = 1'b0; start = 1'b0; stop = 1'b0;
      pause = 1'b0; dir = 1'b0; speed = 6'd8;
      step(); step();
      reset = 1'b0;
      step();
      chk("rst_x0", int'(x0), 0);
      chk("rst_y0", int'(y0), 224);
      chk("rst_moving", int'(moving), 0);
      chk("rst_wrap", int'(wrap), 0);

      start = 1'b1; step(); start = 1'b0;
      chk("start_moving", int'(moving), 1);
      chk("start_x0", int'(x0), 0);
      tick("s8_a", 2, 0);
      tick("s8_b", 4, 0);
      tick("s8_c", 6, 0);

      stop = 1'b1; step(); stop = 1'b0;
      chk("stop_x0", int'(x0), 0);
      chk("stop_moving", int'(moving), 0);

      start = 1'b1; step(); start = 1'b0;
      speed = 6'd5;
      tick("s5_a", 1, 0);
      tick("s5_b", 2, 0);
      tick("s5_c", 3, 0);
      tick("s5_d", 5, 0);
      tick("s5_e", 6, 0);

      pause = 1'b1; step();
      chk("pause_moving", int'(moving), 0);
      tick("pause_a", 6, 0);
      tick("pause_b", 6, 0);
      chk("pause_moving2", int'(moving), 0);
      pause = 1'b0; step();
      chk("resume_moving", int'(moving), 1);
      speed = 6'd7;
      tick("resume_frac", 8, 0);
      speed = 6'd0;
      tick("speed0", 8, 0);

      speed = 6'd12;
      stop = 1'b1; frame_tick = 1'b1; step();
      stop = 1'b0; frame_tick = 1'b0;
      chk("stop_tick_x0", int'(x0), 0);
      chk("stop_tick_moving", int'(moving), 0);

      start = 1'b1; stop = 1'b1; step();
      start = 1'b0; stop = 1'b0;
      chk("start_stop_moving", int'(moving), 0);
      step();
      chk("start_stop_idle", int'(moving), 0);

      speed = 6'd16; dir = 1'b1;
      start = 1'b1; frame_tick = 1'b1; step();
      start = 1'b0; frame_tick = 1'b0;
      chk("start_tick_x0", int'(x0), 0);
      chk("start_tick_moving", int'(moving), 1);
      tick("left_wrap", 636, 1);
      dir = 1'b0; speed = 6'd32;
      tick("right_wrap", 4, 1);
      dir = 1'b1; speed = 6'd4;
      tick("left_one", 3, 0);
      speed = 6'd16;
      tick("left_wrap2", 639, 1);

      speed = 6'd32; dir = 1'b0;
      reset = 1'b1; frame_tick = 1'b1; step();
      reset = 1'b0; frame_tick = 1'b0;
      chk("rst_run_x0", int'(x0), 0);
      chk("rst_run_wrap", int'(wrap), 0);
      chk("rst_run_moving", int'(moving), 0);
      tick("rst_run_idle", 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
